// File: rtl/wb_instr_loader.sv
// Wishbone initiator that streams a byte-wide program image into instruction
// memory, one single-beat write per byte at an auto-incrementing word address.
module wb_instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  load_len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i
);

  localparam int unsigned IDX_W = 9;
  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_inc;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              error_q, error_d;
  logic              done_q, done_d;

  assign idx_inc = IDX_W'(idx_q + IDX_W'(1));

  // Next-state and next-output logic for the load sequencer
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    error_d = error_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          len_d   = load_len;
          idx_d   = '0;
          if (load_len == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (byte_valid) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = 4'b0001;
          adr_d   = BASE_ADDR + 32'({idx_q, 2'b00});
          dat_d   = {24'd0, byte_data};
          tmo_d   = '0;
          state_d = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (wbm_ack_i) begin
          // ack takes priority over a coincident timeout
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = 4'b0000;
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'b0000;
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = TMO_W'(tmo_q + TMO_W'(1));
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

  // Handshake and status decoded directly from the state register
  assign byte_ready = (state_q == LOAD);
  assign busy       = (state_q == LOAD) || (state_q == WAIT_ACK);

  assign done      = done_q;
  assign error     = error_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_instr_loader.sv
// Self-checking bench for wb_instr_loader: random byte gaps and responder
// latency, compared against a list of expected writes built from the byte stream.
module tb_wb_instr_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int unsigned TMO  = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;

  wb_instr_loader #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .busy(busy), .done(done), .error(error),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        stable;
  } wr_t;

  wr_t        obs_q[$];
  logic [7:0] bytes_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int done_count = 0;
  int cyc_cycles = 0;
  int ready_viol = 0;
  int ack_delay  = 1;
  bit withhold   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Wishbone responder and bus monitor, sampled on the falling edge
  initial begin
    int          wait_cnt = 0;
    logic [31:0] first_adr = '0;
    logic [31:0] first_dat = '0;
    bit          stable = 1'b1;
    wbm_ack_i = 1'b0;
    forever begin
      @(negedge clock);
      if (done === 1'b1) done_count++;
      if (wbm_cyc_o === 1'b1) cyc_cycles++;
      if (byte_ready === 1'b1 && wbm_cyc_o === 1'b1) ready_viol++;
      if (reset !== 1'b1 && wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1) begin
        if (wait_cnt == 0) begin
          first_adr = wbm_adr_o;
          first_dat = wbm_dat_o;
          stable = 1'b1;
        end else if (wbm_adr_o !== first_adr || wbm_dat_o !== first_dat) begin
          stable = 1'b0;
        end
        if (!withhold && wait_cnt >= ack_delay) begin
          wbm_ack_i = 1'b1;
          obs_q.push_back('{adr: wbm_adr_o, dat: wbm_dat_o, sel: wbm_sel_o,
                            we: wbm_we_o, stable: stable});
        end else begin
          wbm_ack_i = 1'b0;
        end
        wait_cnt++;
      end else begin
        wbm_ack_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Present one byte after a gap; returns on the falling edge after transfer
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      n_assert++;
      n_fail++;
      $error("FAIL byte_accept_timeout: observed ready=%b expected 1", byte_ready);
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [8:0] len);
    @(negedge clock);
    start = 1'b1;
    load_len = len;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Full load of bytes_q; expected writes are BASE + 4*n carrying byte n
  task automatic run_load(input string tag, input int delay, input int maxgap);
    int n = 0;
    int d0;
    obs_q.delete();
    ack_delay = delay;
    withhold  = 1'b0;
    d0 = done_count;
    pulse_start(9'(bytes_q.size()));
    chk({tag, "_error_clear"}, 32'(error), 32'd0);
    foreach (bytes_q[i]) send_byte(bytes_q[i], $urandom_range(0, maxgap));
    while (done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    repeat (3) @(negedge clock);
    #1;
    chk({tag, "_done_once"}, 32'(done_count - d0), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(bytes_q.size()));
    foreach (bytes_q[i]) begin
      if (i < obs_q.size()) begin
        chk({tag, $sformatf("_adr%0d", i)}, obs_q[i].adr, BASE + 32'(4 * i));
        chk({tag, $sformatf("_dat%0d", i)}, obs_q[i].dat, {24'd0, bytes_q[i]});
        if (obs_q[i].sel !== 4'b0001 || obs_q[i].we !== 1'b1 || obs_q[i].stable !== 1'b1)
          chk({tag, $sformatf("_ctl%0d", i)},
              {27'd0, obs_q[i].stable, obs_q[i].we, obs_q[i].sel}, {27'd0, 1'b1, 1'b1, 4'b0001});
      end
    end
  endtask

  initial begin
    int d0;
    int n;
    reset = 1'b1;
    start = 1'b0;
    load_len = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_status", {28'd0, byte_ready, busy, done, error}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1) three fixed bytes, ack one cycle after strobe
    bytes_q = '{8'hA1, 8'hB2, 8'hC3};
    run_load("t1", 1, 0);

    // 2) zero-length load: done pulses once, bus untouched
    cyc_cycles = 0;
    d0 = done_count;
    @(negedge clock);
    start = 1'b1;
    load_len = 9'd0;
    @(negedge clock);
    start = 1'b0;
    chk("t2_done_hi", 32'(done), 32'd1);
    @(negedge clock);
    chk("t2_done_lo", 32'(done), 32'd0);
    repeat (2) @(negedge clock);
    #1;
    chk("t2_done_once", 32'(done_count - d0), 32'd1);
    chk("t2_no_cyc", 32'(cyc_cycles), 32'd0);

    // 3) responder withholds ack -> timeout, then a clean reload
    withhold = 1'b1;
    obs_q.delete();
    d0 = done_count;
    pulse_start(9'd2);
    cyc_cycles = 0;
    send_byte(8'h5A, 0);
    n = 0;
    while (wbm_cyc_o === 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    #1;
    chk("t3_cyc_len", 32'(cyc_cycles), 32'(TMO));
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_no_done", 32'(done_count - d0), 32'd0);
    chk("t3_no_ack", 32'(obs_q.size()), 32'd0);
    bytes_q = '{8'h11, 8'h22};
    run_load("t3r", 1, 0);

    // 4) random gaps, ack delayed 5 cycles, random data
    ready_viol = 0;
    bytes_q.delete();
    for (int i = 0; i < 6; i++) bytes_q.push_back(8'($urandom));
    run_load("t4", 5, 4);
    chk("t4_ready_in_wait", 32'(ready_viol), 32'd0);

    // 5) full 256-byte image with random responder latency 0..2
    bytes_q.delete();
    for (int i = 0; i < 256; i++) bytes_q.push_back(8'(i));
    run_load("t5", int'($urandom_range(0, 2)), 1);
    if (obs_q.size() == 256) begin
      chk("t5_last_adr", obs_q[255].adr, BASE + 32'h3FC);
      chk("t5_last_dat", obs_q[255].dat, 32'hFF);
    end

    // 6) start ignored while busy; reset mid-cycle clears everything
    withhold = 1'b1;
    d0 = done_count;
    pulse_start(9'd4);
    send_byte(8'h77, 0);
    @(negedge clock);
    start = 1'b1;
    load_len = 9'd0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #1;
    chk("t6_ign_done", 32'(done_count - d0), 32'd0);
    chk("t6_ign_busy", 32'(busy), 32'd1);
    chk("t6_ign_cyc", 32'(wbm_cyc_o), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rst_bus", {25'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'd0);
    chk("t6_rst_adr", wbm_adr_o, 32'd0);
    chk("t6_rst_dat", wbm_dat_o, 32'd0);
    chk("t6_rst_status", {28'd0, byte_ready, busy, done, error}, 32'd0);
    reset = 1'b0;
    withhold = 1'b0;
    bytes_q = '{8'h3C};
    run_load("t6r", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
